ysyx_22040750_trap_ctrl: RTL and testbench

//  Trap sequencer between the WB stage, the CSR file and the IFU. Accepts ecall, mret and a pending

---
 rtl/ysyx_22040750_trap_ctrl_pkg.sv | 22 ++
 rtl/ysyx_22040750_trap_ctrl_if.sv | 21 ++
 rtl/ysyx_22040750_trap_ctrl.sv | 127 ++++++++++++
 tb/tb_ysyx_22040750_trap_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040750_trap_ctrl_pkg.sv
// Shared types and constants for the trap sequencer.
// FSM states, trap kinds and the mcause values it writes.
package ysyx_22040750_defs;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } kind_t;

  localparam logic [63:0] ECALL_CAUSE_M =
    64'd11;
  localparam logic [63:0] TIMER_CAUSE_M =
    64'h8000_0000_0000_0007;

endpackage

// File: rtl/ysyx_22040750_trap_ctrl_if.sv
// Redirect handshake from the trap sequencer to the IFU.
// Master drives valid/pc, slave answers with ready.
interface ysyx_22040750_trap_ctrl_if;

  logic        O_redirect_valid;
  logic [31:0] O_redirect_pc;
  logic        I_ifu_ready;

  modport master (
    output O_redirect_valid,
    output O_redirect_pc,
    input  I_ifu_ready
  );

  modport slave (
    input  O_redirect_valid,
    input  O_redirect_pc,
    output I_ifu_ready
  );

endinterface

// File: rtl/ysyx_22040750_trap_ctrl.sv
// Trap sequencer: accepts ecall/mret/timer at WB, drains memory,
// strobes the CSR file, flushes, then redirects the IFU.
module ysyx_22040750_trap_ctrl
  import ysyx_22040750_defs::*;
#(
  parameter logic [63:0] ECALL_CAUSE = ECALL_CAUSE_M,
  parameter logic [63:0] TIMER_CAUSE = TIMER_CAUSE_M
) (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_wb_valid,
  input  logic        I_wb_ecall,
  input  logic        I_wb_mret,
  input  logic [31:0] I_wb_pc,
  input  logic        I_timer_pend,
  input  logic        I_mem_busy,
  input  logic [63:0] I_mtvec,
  input  logic [63:0] I_mepc,
  output logic        O_wb_kill,
  output logic        O_stall,
  output logic        O_flush,
  output logic        O_csr_trap_wr,
  output logic        O_csr_mret_wr,
  output logic [31:0] O_csr_epc,
  output logic [63:0] O_csr_cause,
  ysyx_22040750_trap_ctrl_if.master redirect
);

  state_t      state_q;
  state_t      state_d;
  kind_t       kind_q;
  logic [31:0] epc_q;
  logic [63:0] cause_q;
  logic [31:0] redir_q;
  logic        redir_valid;

  logic take_ecall;
  logic take_mret;
  logic take_timer;
  logic accept;

  // Only direct-mode mtvec and a 32-bit PC space are supported.
  logic unused_bits;
  assign unused_bits = ^{I_mtvec[63:32], I_mtvec[1:0],
                         I_mepc[63:32]};

  always_comb begin
    take_ecall = I_wb_valid & I_wb_ecall;
    take_mret  = I_wb_valid & I_wb_mret & ~I_wb_ecall;
    take_timer = I_wb_valid & I_timer_pend
               & ~I_wb_ecall & ~I_wb_mret;
    accept        = 1'b0;
    state_d       = state_q;
    O_wb_kill     = 1'b0;
    O_stall       = 1'b0;
    O_flush       = 1'b0;
    O_csr_trap_wr = 1'b0;
    O_csr_mret_wr = 1'b0;
    redir_valid   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        accept    = ~I_rst
                  & (take_ecall | take_mret | take_timer);
        O_wb_kill = ~I_rst & take_timer;
        O_stall   = accept;
        if (accept)
          state_d = I_mem_busy ? ST_DRAIN : ST_COMMIT;
      end
      ST_DRAIN: begin
        O_stall = 1'b1;
        if (!I_mem_busy)
          state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        O_stall       = 1'b1;
        O_flush       = 1'b1;
        O_csr_trap_wr = (kind_q == KIND_TRAP);
        O_csr_mret_wr = (kind_q == KIND_MRET);
        state_d       = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        O_stall     = 1'b1;
        redir_valid = 1'b1;
        if (redirect.I_ifu_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Target is captured once so it cannot move while valid.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      kind_q  <= KIND_TRAP;
      epc_q   <= '0;
      cause_q <= '0;
      redir_q <= '0;
    end else begin
      if (accept) begin
        kind_q <= take_mret ? KIND_MRET : KIND_TRAP;
        if (!take_mret) begin
          epc_q   <= I_wb_pc;
          cause_q <= take_ecall ? ECALL_CAUSE
                                : TIMER_CAUSE;
        end
      end
      if (state_q == ST_COMMIT)
        redir_q <= (kind_q == KIND_TRAP)
                 ? {I_mtvec[31:2], 2'b00}
                 : I_mepc[31:0];
    end
  end

  assign O_csr_epc   = epc_q;
  assign O_csr_cause = cause_q;

  assign redirect.O_redirect_valid = redir_valid;
  assign redirect.O_redirect_pc    = redir_q;

endmodule

// File: tb/tb_ysyx_22040750_trap_ctrl.sv
// Directed plus randomized checks of the trap sequencer.
// Expected timelines come from a transaction-level model.
module tb_ysyx_22040750_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        wb_ecall;
  logic        wb_mret;
  logic [31:0] wb_pc;
  logic        timer_pend;
  logic        mem_busy;
  logic [63:0] mtvec;
  logic [63:0] mepc;
  logic        wb_kill;
  logic        stall;
  logic        flush;
  logic        trap_wr;
  logic        mret_wr;
  logic [31:0] csr_epc;
  logic [63:0] csr_cause;

  int tests  = 0;
  int failed = 0;

  logic [31:0] m_epc;
  logic [63:0] m_cause;

  ysyx_22040750_trap_ctrl_if bus ();

  ysyx_22040750_trap_ctrl dut (
    .I_sys_clk     (clk),
    .I_rst         (rst),
    .I_wb_valid    (wb_valid),
    .I_wb_ecall    (wb_ecall),
    .I_wb_mret     (wb_mret),
    .I_wb_pc       (wb_pc),
    .I_timer_pend  (timer_pend),
    .I_mem_busy    (mem_busy),
    .I_mtvec       (mtvec),
    .I_mepc        (mepc),
    .O_wb_kill     (wb_kill),
    .O_stall       (stall),
    .O_flush       (flush),
    .O_csr_trap_wr (trap_wr),
    .O_csr_mret_wr (mret_wr),
    .O_csr_epc     (csr_epc),
    .O_csr_cause   (csr_cause),
    .redirect      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic quiet_wb();
    wb_valid   = 1'b0;
    wb_ecall   = 1'b0;
    wb_mret    = 1'b0;
    timer_pend = 1'b0;
  endtask

  task automatic noise_wb();
    wb_valid   = 1'($urandom);
    wb_ecall   = 1'($urandom);
    wb_mret    = 1'($urandom);
    timer_pend = 1'($urandom);
    wb_pc      = $urandom;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 64'(stall), 0);
    chk({tag, "_flush"}, 64'(flush), 0);
    chk({tag, "_trapwr"}, 64'(trap_wr), 0);
    chk({tag, "_mretwr"}, 64'(mret_wr), 0);
    chk({tag, "_kill"}, 64'(wb_kill), 0);
    chk({tag, "_valid"}, 64'(bus.O_redirect_valid), 0);
    chk({tag, "_rpc"}, 64'(bus.O_redirect_pc), 0);
    chk({tag, "_epc"}, 64'(csr_epc), 0);
    chk({tag, "_cause"}, csr_cause, 0);
  endtask

  // One request at WB; nbusy = busy cycles from acceptance,
  // nwait = cycles the IFU holds ready low in redirect.
  task automatic run_txn(input string tag,
                         input bit ec, input bit mr,
                         input bit tp,
                         input logic [31:0] pc,
                         input logic [63:0] tvec,
                         input logic [63:0] epc_in,
                         input int nbusy, input int nwait);
    bit          trap;
    bit          kill;
    logic [31:0] exp_pc;
    int          c;
    int          last;
    trap   = ec || !mr;
    kill   = tp && !ec && !mr;
    exp_pc = trap ? {tvec[31:2], 2'b00} : epc_in[31:0];
    if (trap) begin
      m_epc   = pc;
      m_cause = ec ? 64'd11 : 64'h8000_0000_0000_0007;
    end
    c    = nbusy + 1;
    last = c + 2 + nwait;

    @(posedge clk); #1;
    wb_valid   = 1'b1;
    wb_ecall   = ec;
    wb_mret    = mr;
    timer_pend = tp;
    wb_pc      = pc;
    mem_busy   = (nbusy > 0);
    bus.I_ifu_ready = 1'($urandom);
    mtvec = {$urandom, $urandom};
    mepc  = {$urandom, $urandom};
    @(negedge clk);
    chk({tag, "_t0_kill"}, 64'(wb_kill), 64'(kill));
    chk({tag, "_t0_stall"}, 64'(stall), 1);
    chk({tag, "_t0_flush"}, 64'(flush), 0);

    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      if (k == last) quiet_wb();
      else noise_wb();
      mem_busy = (k < nbusy);
      if (k >= c + 1 + nwait)
        bus.I_ifu_ready = (k != last);
      else if (k > c)
        bus.I_ifu_ready = 1'b0;
      else
        bus.I_ifu_ready = 1'($urandom);
      mtvec = (k == c) ? tvec : {$urandom, $urandom};
      mepc  = (k == c) ? epc_in : {$urandom, $urandom};
      @(negedge clk);
      chk({tag, "_stall"}, 64'(stall), 64'(k < last));
      chk({tag, "_flush"}, 64'(flush), 64'(k == c));
      chk({tag, "_trapwr"}, 64'(trap_wr),
          64'(k == c && trap));
      chk({tag, "_mretwr"}, 64'(mret_wr),
          64'(k == c && !trap));
      chk({tag, "_valid"}, 64'(bus.O_redirect_valid),
          64'(k > c && k < last));
      chk({tag, "_kill"}, 64'(wb_kill), 0);
      if (k > c && k < last)
        chk({tag, "_rpc"}, 64'(bus.O_redirect_pc),
            64'(exp_pc));
      if (k >= c) begin
        chk({tag, "_epc"}, 64'(csr_epc), 64'(m_epc));
        chk({tag, "_cause"}, csr_cause, m_cause);
      end
    end
  endtask

  // Accept an ecall, then reset inside DRAIN or REDIRECT.
  task automatic reset_mid(input string tag,
                           input bit in_redirect);
    int n;
    n = in_redirect ? 2 : 1;
    @(posedge clk); #1;
    wb_valid = 1'b1;
    wb_ecall = 1'b1;
    wb_pc    = $urandom;
    mem_busy = !in_redirect;
    bus.I_ifu_ready = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      quiet_wb();
      mem_busy = !in_redirect;
      if (k == n) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst      = 1'b0;
    mem_busy = 1'b0;
    bus.I_ifu_ready = 1'b1;
    m_epc   = '0;
    m_cause = '0;
    @(negedge clk);
    chk_all_zero({tag, "_r1"});
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero({tag, "_r2"});
  endtask

  initial begin
    bit ec;
    bit mr;
    bit tp;
    int sel;
    rst      = 1'b1;
    quiet_wb();
    wb_pc    = '0;
    mem_busy = 1'b0;
    mtvec    = '0;
    mepc     = '0;
    bus.I_ifu_ready = 1'b0;
    m_epc    = '0;
    m_cause  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    run_txn("ecall", 1, 0, 0, 32'h8000_0010,
            64'h8000_0101, {$urandom, $urandom}, 0, 0);
    run_txn("mret", 0, 1, 0, $urandom,
            {$urandom, $urandom}, 64'h8000_0014, 0, 0);
    run_txn("timer", 0, 0, 1, 32'h8000_0040,
            {$urandom, $urandom}, {$urandom, $urandom},
            3, 0);
    run_txn("ec_tmr", 1, 0, 1, $urandom,
            {$urandom, $urandom}, {$urandom, $urandom},
            0, 0);
    run_txn("rdy_low", 1, 0, 0, $urandom,
            {$urandom, $urandom}, {$urandom, $urandom},
            0, 4);

    @(posedge clk); #1;
    quiet_wb();
    timer_pend = 1'b1;
    @(negedge clk);
    chk("nv_tmr_stall", 64'(stall), 0);
    chk("nv_tmr_kill", 64'(wb_kill), 0);
    @(posedge clk); #1;
    timer_pend = 1'b0;
    @(negedge clk);
    chk("nv_tmr_flush", 64'(flush), 0);
    chk("nv_tmr_trapwr", 64'(trap_wr), 0);

    reset_mid("rst_drain", 0);
    reset_mid("rst_redir", 1);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(1, 7);
      ec  = sel[0];
      mr  = sel[1];
      tp  = sel[2];
      run_txn($sformatf("rnd%0d", i), ec, mr, tp,
              $urandom, {$urandom, $urandom},
              {$urandom, $urandom},
              $urandom_range(0, 3),
              $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end

endmodule
